gmii_tx_framer: RTL and testbench

Byte-wide Ethernet transmit framer that converts an AXI-stream frame into GMII transmit signalling: preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS and inter-frame gap. It sits directly upstream of the GMII PHY model and drives its `phy_txd` / `phy_tx_en` / `phy_tx_er` inputs, clocked by the PHY gigabit transmit clock.

---
 rtl/gmii_pkg.sv | 20 ++
 rtl/eth_crc32_d8.sv | 17 +
 rtl/gmii_tx_framer.sv | 163 ++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared Ethernet framing constants and transmit FSM states
package gmii_pkg;

    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational reflected CRC-32 update for one byte
module eth_crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        o_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            o_crc = (o_crc >> 1) ^ (((o_crc[0] ^ i_data[i]) != 1'b0) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - AXI-stream to GMII transmit framer with padding, FCS and IFG
module gmii_tx_framer
    import gmii_pkg::*;
#(
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int IFG              = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    localparam logic [15:0] PAD_LEN = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [7:0]  GAP_LEN = 8'(IFG);

    tx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_step;
    logic [31:0] r_crc;
    logic        r_bad;
    logic [7:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_start;
    logic        r_uf;

    logic [7:0]  w_crc_data;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;
    logic [15:0] w_cnt_inc;
    logic        w_pad_more;

    assign w_crc_data = (r_state == ST_PAD) ? 8'h00 : s_axis_tdata;

    eth_crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_data),
        .o_crc  (w_crc_next)
    );

    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_pad_more = (ENABLE_PADDING != 0) && (w_cnt_inc < PAD_LEN);
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = 8'(w_fcs >> {r_step[1:0], 3'b000});

    assign s_axis_tready = (r_state == ST_SFD) || (r_state == ST_PAYLOAD) || (r_state == ST_DRAIN);

    // Outputs are registered alongside the state: each edge decides what the next cycle drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_step  <= '0;
            r_crc   <= '1;
            r_bad   <= 1'b0;
            r_txd   <= '0;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_start <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_uf    <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (r_state == ST_GAP && r_step != 8'd0) begin
                        r_step <= r_step - 8'd1;
                    end else if (s_axis_tvalid) begin
                        r_state <= ST_PREAMBLE;
                        r_txd   <= ETH_PRE;
                        r_tx_en <= 1'b1;
                        r_start <= 1'b1;
                        r_step  <= '0;
                        r_cnt   <= '0;
                        r_bad   <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_step == 8'd6) begin
                        r_state <= ST_SFD;
                        r_txd   <= ETH_SFD;
                        r_crc   <= '1;
                    end else begin
                        r_txd  <= ETH_PRE;
                        r_step <= r_step + 8'd1;
                    end
                end
                ST_SFD, ST_PAYLOAD: begin
                    if (s_axis_tvalid) begin
                        r_txd   <= s_axis_tdata;
                        r_crc   <= w_crc_next;
                        r_cnt   <= w_cnt_inc;
                        r_state <= ST_PAYLOAD;
                        if (s_axis_tlast) begin
                            r_bad   <= s_axis_tuser;
                            r_step  <= '0;
                            r_state <= w_pad_more ? ST_PAD : ST_FCS;
                        end
                    end else begin
                        // Source ran dry mid-frame: poison the frame on the wire, then swallow the rest.
                        r_txd   <= '0;
                        r_tx_er <= 1'b1;
                        r_uf    <= 1'b1;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_PAD: begin
                    r_txd   <= '0;
                    r_tx_er <= r_bad;
                    r_crc   <= w_crc_next;
                    r_cnt   <= w_cnt_inc;
                    if (w_cnt_inc == PAD_LEN) begin
                        r_state <= ST_FCS;
                        r_step  <= '0;
                    end
                end
                ST_FCS: begin
                    r_txd   <= w_fcs_byte;
                    r_tx_er <= r_bad;
                    if (r_step == 8'd3) begin
                        r_state <= ST_GAP;
                        r_step  <= GAP_LEN;
                    end else begin
                        r_step <= r_step + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= ST_GAP;
                        r_step  <= GAP_LEN - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gmii_txd        = r_txd;
    assign gmii_tx_en      = r_tx_en;
    assign gmii_tx_er      = r_tx_er;
    assign start_packet    = r_start;
    assign error_underflow = r_uf;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - scoreboard bench for gmii_tx_framer against a frame-level model
module tb_gmii_tx_framer;

    localparam int IFG    = 12;
    localparam int MINLEN = 64;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, start_packet, error_underflow;

    logic [7:0] n_tdata;
    logic       n_tvalid, n_tready, n_tlast;
    logic [7:0] n_txd;
    logic       n_tx_en, n_tx_er, n_start, n_uf;

    gmii_tx_framer #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(MINLEN), .IFG(IFG)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .start_packet(start_packet), .error_underflow(error_underflow)
    );

    gmii_tx_framer #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(MINLEN), .IFG(IFG)) dut_nopad (
        .clk(clk), .rst(rst),
        .s_axis_tdata(n_tdata), .s_axis_tvalid(n_tvalid), .s_axis_tready(n_tready),
        .s_axis_tlast(n_tlast), .s_axis_tuser(1'b0),
        .gmii_txd(n_txd), .gmii_tx_en(n_tx_en), .gmii_tx_er(n_tx_er),
        .start_packet(n_start), .error_underflow(n_uf)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Expected wire entries: {end_marker, error_underflow, tx_er, txd}
    logic [10:0] q_exp[$];
    int          q_gap[$];
    logic [7:0]  n_exp[$];
    bit          mon_skip    = 1'b0;
    bit          prev_exists = 1'b0;
    bit          prev_ok     = 1'b0;
    logic [7:0]  asc[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void push_frame(input logic [7:0] pl[$], input bit user, input int uf_at);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        repeat (7) q_exp.push_back({3'b000, 8'h55});
        q_exp.push_back({3'b000, 8'hD5});
        if (uf_at >= 0) begin
            for (int i = 0; i < uf_at; i++) q_exp.push_back({3'b000, pl[i]});
            q_exp.push_back(11'b011_0000_0000);
            q_exp.push_back(11'h400);
            return;
        end
        body = pl;
        while (body.size() < MINLEN - 4) body.push_back(8'h00);
        fcs = crc32(body);
        foreach (body[i]) q_exp.push_back({2'b00, (i >= pl.size()) ? user : 1'b0, body[i]});
        for (int i = 0; i < 4; i++) q_exp.push_back({2'b00, user, fcs[8*i +: 8]});
        q_exp.push_back(11'h400);
    endfunction

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic put(input logic [7:0] d, input bit last, input bit user);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!s_axis_tready) begin
            chk("tready_timeout", {31'b0, s_axis_tready}, 1);
            finish_now();
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input bit user, input int uf_at, input int idle);
        if (!prev_exists) q_gap.push_back(2);
        else if (idle == 0 && prev_ok) q_gap.push_back(1);
        else q_gap.push_back(0);
        push_frame(pl, user, uf_at);
        s_axis_tvalid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        for (int i = 0; i < pl.size(); i++) begin
            if (i == uf_at) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            put(pl[i], i == pl.size() - 1, user);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        prev_exists   = 1'b1;
        prev_ok       = (uf_at < 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((q_exp.size() != 0 || gmii_tx_en) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", q_exp.size(), 0);
        @(posedge clk); #1;
    endtask

    bit m_in    = 1'b0;
    int m_low   = 0;
    int m_index = 0;
    always @(negedge clk) begin : monitor
        logic [10:0] e;
        int          g;
        if (mon_skip) begin
            m_in  = gmii_tx_en;
            m_low = 0;
        end else if (gmii_tx_en) begin
            if (!m_in) begin
                chk("start_packet", {31'b0, start_packet}, 1);
                m_index = 0;
                chk("gap_queue_nonempty", {31'b0, q_gap.size() != 0}, 1);
                if (q_gap.size() != 0) begin
                    g = q_gap.pop_front();
                    if (g == 1) chk("ifg_exact", m_low, IFG);
                    else if (g == 0) chk("ifg_min", {31'b0, m_low >= IFG}, 1);
                end
            end else begin
                chk("start_packet_mid", {31'b0, start_packet}, 0);
            end
            m_in = 1'b1;
            chk("exp_queue_nonempty", {31'b0, q_exp.size() != 0}, 1);
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk($sformatf("frame_byte[%0d]", m_index),
                    {21'b0, 1'b0, error_underflow, gmii_tx_er, gmii_txd}, {21'b0, e});
            end
            m_index++;
        end else begin
            if (m_in) begin
                chk("end_queue_nonempty", {31'b0, q_exp.size() != 0}, 1);
                if (q_exp.size() != 0) begin
                    e = q_exp.pop_front();
                    chk($sformatf("frame_end_at[%0d]", m_index), {21'b0, e}, 32'h400);
                end
                m_low = 0;
            end
            m_in = 1'b0;
            m_low++;
            chk("idle_outputs", {29'b0, gmii_tx_er, error_underflow, start_packet}, 0);
        end
    end

    bit n_in = 1'b0;
    always @(negedge clk) begin : nopad_monitor
        logic [7:0] e;
        if (n_tx_en === 1'b1) begin
            if (!n_in) chk("nopad_start_packet", {31'b0, n_start}, 1);
            n_in = 1'b1;
            chk("nopad_exp_nonempty", {31'b0, n_exp.size() != 0}, 1);
            if (n_exp.size() != 0) begin
                e = n_exp.pop_front();
                chk("nopad_byte", {22'b0, n_uf, n_tx_er, n_txd}, {24'b0, e});
            end
        end else begin
            n_in = 1'b0;
        end
    end

    initial begin : stimulus
        logic [7:0] pl[$];
        int         len, uf, idle, t;
        bit         user;

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        n_tdata = '0; n_tvalid = 1'b0; n_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {24'b0, gmii_txd}, 0);
        chk("rst_tx_en", {31'b0, gmii_tx_en}, 0);
        chk("rst_tx_er", {31'b0, gmii_tx_er}, 0);
        chk("rst_tready", {31'b0, s_axis_tready}, 0);
        chk("rst_start", {31'b0, start_packet}, 0);
        chk("rst_underflow", {31'b0, error_underflow}, 0);
        rst = 1'b0;

        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        send_frame(pl, 1'b0, -1, 0);

        pl.delete();
        pl.push_back(8'h01);
        send_frame(pl, 1'b0, -1, 3);

        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b0, 10, 0);

        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b1, -1, 4);

        for (int f = 0; f < 2; f++) begin
            pl.delete();
            for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
            send_frame(pl, 1'b0, -1, (f == 0) ? 5 : 0);
        end

        for (int f = 0; f < 30; f++) begin
            len  = $urandom_range(1, 90);
            user = ($urandom_range(0, 3) == 0);
            uf   = (len >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
            idle = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            send_frame(pl, user, uf, idle);
        end
        wait_done();

        mon_skip = 1'b1;
        for (int i = 0; i < 6; i++) put(8'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_txd", {24'b0, gmii_txd}, 0);
        chk("midrst_tx_en", {31'b0, gmii_tx_en}, 0);
        chk("midrst_tx_er", {31'b0, gmii_tx_er}, 0);
        chk("midrst_tready", {31'b0, s_axis_tready}, 0);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        mon_skip    = 1'b0;
        prev_exists = 1'b0;

        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b0, -1, 0);
        wait_done();

        repeat (7) n_exp.push_back(8'h55);
        n_exp.push_back(8'hD5);
        foreach (asc[i]) n_exp.push_back(asc[i]);
        n_exp.push_back(8'h26); n_exp.push_back(8'h39); n_exp.push_back(8'hF4); n_exp.push_back(8'hCB);
        for (int i = 0; i < 9; i++) begin
            n_tdata  = asc[i];
            n_tlast  = (i == 8);
            n_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!n_tready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!n_tready) begin
                chk("nopad_tready_timeout", {31'b0, n_tready}, 1);
                finish_now();
            end
            @(posedge clk); #1;
        end
        n_tvalid = 1'b0;
        t = 0;
        while ((n_exp.size() != 0 || n_tx_en) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("nopad_drained", n_exp.size(), 0);

        finish_now();
    end

endmodule
